alu_share_arbiter: RTL and testbench



---
 rtl/alu_share_pkg.sv | 21 ++
 rtl/alu_share_arbiter_rr_arb2.sv | 16 +
 rtl/alu_share_arbiter.sv | 121 ++++++++++++
 tb/tb_alu_share_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_share_pkg.sv
// Shared constants for the ALU share arbiter: ALU op codes, NZCV flag positions, FSM states.
// Definitions only; carries no logic, latency or flow-control behaviour.
package alu_share_pkg;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0001;
   localparam logic [3:0] ALU_AND = 4'b0111;
   localparam logic [3:0] ALU_XOR = 4'b1001;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      RESP
   } state_t;

endpackage

// File: rtl/alu_share_arbiter_rr_arb2.sv
// Two-way round-robin grant; purely combinational (zero latency).
// No backpressure of its own; prio = 0 favours valid0 when both request.
module rr_arb2 (
   input  logic       valid0,
   input  logic       valid1,
   input  logic       prio,
   output logic [1:0] grant
);

   always_comb begin
      grant    = 2'b00;
      grant[0] = valid0 & (~valid1 | ~prio);
      grant[1] = valid1 & (~valid0 | prio);
   end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between two requesters; result registered ALU_LATENCY cycles after accept.
// One op in flight: no request is accepted until the owner's response handshake completes.
module alu_share_arbiter
   import alu_share_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int ALU_LATENCY = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   input  logic             req1_valid,
   output logic             req0_ready,
   output logic             req1_ready,
   input  logic [3:0]       req0_op,
   input  logic [3:0]       req1_op,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic             rsp0_valid,
   output logic             rsp1_valid,
   input  logic             rsp0_ready,
   input  logic             rsp1_ready,
   output logic [WIDTH-1:0] rsp_result,
   output logic [3:0]       rsp_flags,
   output logic [3:0]       alu_ctrl,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   input  logic [WIDTH-1:0] alu_result,
   input  logic [3:0]       alu_flags
);

   localparam logic [3:0] LAT_INIT = 4'(ALU_LATENCY - 1);

   state_t           state_q, state_nxt;
   logic             prio_q;
   logic             owner_q;
   logic [3:0]       cnt_q;
   logic [3:0]       op_q;
   logic [WIDTH-1:0] a_q, b_q;
   logic [1:0]       gnt;

   rr_arb2 u_arb (
      .valid0 (req0_valid),
      .valid1 (req1_valid),
      .prio   (prio_q),
      .grant  (gnt)
   );

   always_comb begin
      state_nxt  = state_q;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      rsp0_valid = 1'b0;
      rsp1_valid = 1'b0;
      alu_ctrl   = ALU_ADD;
      alu_a      = '0;
      alu_b      = '0;
      case (state_q)
         IDLE: begin
            // grant is only ever set for a requester whose valid is high
            req0_ready = gnt[0];
            req1_ready = gnt[1];
            if (|gnt) state_nxt = EXEC;
         end
         EXEC: begin
            alu_ctrl = op_q;
            alu_a    = a_q;
            alu_b    = b_q;
            if (cnt_q == 4'd0) state_nxt = RESP;
         end
         RESP: begin
            rsp0_valid = ~owner_q;
            rsp1_valid = owner_q;
            if (owner_q ? rsp1_ready : rsp0_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         prio_q     <= 1'b0;
         owner_q    <= 1'b0;
         cnt_q      <= 4'd0;
         op_q       <= 4'd0;
         a_q        <= '0;
         b_q        <= '0;
         rsp_result <= '0;
         rsp_flags  <= 4'd0;
      end else begin
         state_q <= state_nxt;
         case (state_q)
            IDLE: begin
               if (|gnt) begin
                  owner_q <= gnt[1];
                  op_q    <= gnt[1] ? req1_op : req0_op;
                  a_q     <= gnt[1] ? req1_a  : req0_a;
                  b_q     <= gnt[1] ? req1_b  : req0_b;
                  cnt_q   <= LAT_INIT;
               end
            end
            EXEC: begin
               if (cnt_q != 4'd0) begin
                  cnt_q <= cnt_q - 4'd1;
               end else begin
                  rsp_result <= alu_result;
                  rsp_flags  <= alu_flags;
               end
            end
            RESP: begin
               if (state_nxt == IDLE) prio_q <= ~owner_q;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: one instance at ALU_LATENCY=1, one at ALU_LATENCY=4.
// A behavioural ALU per instance closes the loop; expected values are hand-computed constants.
module tb_alu_share_arbiter;
   import alu_share_pkg::*;

   logic clk;
   logic rst;

   logic        req0_valid, req1_valid, req0_ready, req1_ready;
   logic [3:0]  req0_op, req1_op;
   logic [31:0] req0_a, req0_b, req1_a, req1_b;
   logic        rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
   logic [31:0] rsp_result;
   logic [3:0]  rsp_flags;
   logic [3:0]  alu_ctrl;
   logic [31:0] alu_a, alu_b, alu_result;
   logic [3:0]  alu_flags;

   logic        d4_req0_valid, d4_req1_valid, d4_req0_ready, d4_req1_ready;
   logic [3:0]  d4_req0_op, d4_req1_op;
   logic [31:0] d4_req0_a, d4_req0_b, d4_req1_a, d4_req1_b;
   logic        d4_rsp0_valid, d4_rsp1_valid, d4_rsp0_ready, d4_rsp1_ready;
   logic [31:0] d4_rsp_result;
   logic [3:0]  d4_rsp_flags;
   logic [3:0]  d4_alu_ctrl;
   logic [31:0] d4_alu_a, d4_alu_b, d4_alu_result;
   logic [3:0]  d4_alu_flags;

   int checks = 0;
   int errors = 0;

   alu_share_arbiter #(.WIDTH(32), .ALU_LATENCY(1)) u_dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req1_valid(req1_valid),
      .req0_ready(req0_ready), .req1_ready(req1_ready),
      .req0_op(req0_op), .req1_op(req1_op),
      .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
      .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
      .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
      .rsp_result(rsp_result), .rsp_flags(rsp_flags),
      .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b),
      .alu_result(alu_result), .alu_flags(alu_flags)
   );

   alu_share_arbiter #(.WIDTH(32), .ALU_LATENCY(4)) u_dut4 (
      .clk(clk), .rst(rst),
      .req0_valid(d4_req0_valid), .req1_valid(d4_req1_valid),
      .req0_ready(d4_req0_ready), .req1_ready(d4_req1_ready),
      .req0_op(d4_req0_op), .req1_op(d4_req1_op),
      .req0_a(d4_req0_a), .req0_b(d4_req0_b), .req1_a(d4_req1_a), .req1_b(d4_req1_b),
      .rsp0_valid(d4_rsp0_valid), .rsp1_valid(d4_rsp1_valid),
      .rsp0_ready(d4_rsp0_ready), .rsp1_ready(d4_rsp1_ready),
      .rsp_result(d4_rsp_result), .rsp_flags(d4_rsp_flags),
      .alu_ctrl(d4_alu_ctrl), .alu_a(d4_alu_a), .alu_b(d4_alu_b),
      .alu_result(d4_alu_result), .alu_flags(d4_alu_flags)
   );

   function automatic logic [35:0] alu_model(input logic [3:0] c, input logic [31:0] a,
                                             input logic [31:0] b);
      logic [32:0] s;
      logic [31:0] r;
      logic        cy;
      logic        v;
      s  = 33'd0;
      r  = 32'd0;
      cy = 1'b0;
      v  = 1'b0;
      case (c)
         ALU_ADD: begin
            s  = {1'b0, a} + {1'b0, b};
            r  = s[31:0];
            cy = s[32];
            v  = (a[31] == b[31]) && (r[31] != a[31]);
         end
         ALU_SUB: begin
            s  = {1'b0, a} - {1'b0, b};
            r  = s[31:0];
            cy = ~s[32];
            v  = (a[31] != b[31]) && (r[31] != a[31]);
         end
         ALU_AND: r = a & b;
         ALU_XOR: r = a ^ b;
         default: r = 32'd0;
      endcase
      return {r[31], (r == 32'd0), cy, v, r};
   endfunction

   always_comb {alu_flags, alu_result} = alu_model(alu_ctrl, alu_a, alu_b);
   always_comb {d4_alu_flags, d4_alu_result} = alu_model(d4_alu_ctrl, d4_alu_a, d4_alu_b);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      req0_valid = 0; req1_valid = 0; req0_op = 0; req1_op = 0;
      req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
      rsp0_ready = 0; rsp1_ready = 0;
      d4_req0_valid = 0; d4_req1_valid = 0; d4_req0_op = 0; d4_req1_op = 0;
      d4_req0_a = 0; d4_req0_b = 0; d4_req1_a = 0; d4_req1_b = 0;
      d4_rsp0_ready = 0; d4_rsp1_ready = 0;
      tick();
      tick();
      rst = 1'b0;
      #1;

      // reset values
      check("rst_req_ready", 32'({req1_ready, req0_ready}), 32'd0);
      check("rst_rsp_valid", 32'({rsp1_valid, rsp0_valid}), 32'd0);
      check("rst_rsp_result", rsp_result, 32'd0);
      check("rst_rsp_flags", 32'(rsp_flags), 32'd0);
      check("rst_alu_ctrl", 32'(alu_ctrl), 32'd0);
      check("rst_alu_a", alu_a, 32'd0);
      check("rst_alu_b", alu_b, 32'd0);

      // single ADD on requester 0, latency 1
      req0_valid = 1; req0_op = ALU_ADD; req0_a = 5; req0_b = 3; rsp0_ready = 1;
      #1;
      check("add_req0_ready_N", 32'(req0_ready), 32'd1);
      check("add_req1_ready_N", 32'(req1_ready), 32'd0);
      tick();
      req0_valid = 0;
      #1;
      check("add_alu_ctrl_N1", 32'(alu_ctrl), 32'h0);
      check("add_alu_a_N1", alu_a, 32'd5);
      check("add_alu_b_N1", alu_b, 32'd3);
      check("add_rsp0_valid_N1", 32'(rsp0_valid), 32'd0);
      tick();
      check("add_rsp0_valid_N2", 32'(rsp0_valid), 32'd1);
      check("add_rsp1_valid_N2", 32'(rsp1_valid), 32'd0);
      check("add_result", rsp_result, 32'd8);
      check("add_flags", 32'(rsp_flags), 32'h0);
      tick();
      check("add_rsp0_valid_N3", 32'(rsp0_valid), 32'd0);
      check("add_idle_alu_a_N3", alu_a, 32'd0);

      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;

      // simultaneous requests after reset: requester 0 first, then 1
      req0_valid = 1; req0_op = ALU_SUB; req0_a = 3; req0_b = 3;
      req1_valid = 1; req1_op = ALU_XOR; req1_a = 32'hF0; req1_b = 32'h0F;
      rsp0_ready = 1; rsp1_ready = 1;
      #1;
      check("sim_grant_first", 32'({req1_ready, req0_ready}), 32'b01);
      tick();
      check("sim_exec_no_ready", 32'({req1_ready, req0_ready}), 32'b00);
      tick();
      check("sim_rsp0_valid", 32'({rsp1_valid, rsp0_valid}), 32'b01);
      check("sim_sub_result", rsp_result, 32'd0);
      check("sim_sub_zflag", 32'(rsp_flags[FLAG_Z]), 32'd1);
      tick();
      check("sim_grant_second", 32'({req1_ready, req0_ready}), 32'b10);
      tick();
      tick();
      check("sim_rsp1_valid", 32'({rsp1_valid, rsp0_valid}), 32'b10);
      check("sim_xor_result", rsp_result, 32'hFF);
      req0_valid = 0; req1_valid = 0;
      tick();

      // fairness: both valid held continuously over six transactions
      req0_valid = 1; req1_valid = 1;
      #1;
      for (int i = 0; i < 6; i++) begin
         check("rr_grant", 32'({req1_ready, req0_ready}), (i % 2 == 1) ? 32'b10 : 32'b01);
         tick();
         tick();
         check("rr_rsp_valid", 32'({rsp1_valid, rsp0_valid}), (i % 2 == 1) ? 32'b10 : 32'b01);
         check("rr_result", rsp_result, (i % 2 == 1) ? 32'hFF : 32'd0);
         if (i == 5) begin
            req0_valid = 0; req1_valid = 0;
         end
         tick();
      end

      // stray rsp1_ready while requester 0 owns the response
      req0_valid = 1; req0_op = ALU_ADD; req0_a = 5; req0_b = 3;
      rsp0_ready = 0; rsp1_ready = 1;
      #1;
      check("stray_grant", 32'({req1_ready, req0_ready}), 32'b01);
      tick();
      req0_valid = 0;
      tick();
      check("stray_rsp_valid", 32'({rsp1_valid, rsp0_valid}), 32'b01);
      tick();
      check("stray_rsp_valid_held", 32'({rsp1_valid, rsp0_valid}), 32'b01);
      check("stray_result_held", rsp_result, 32'd8);
      rsp1_ready = 0; rsp0_ready = 1;
      tick();
      check("stray_consumed", 32'(rsp0_valid), 32'd0);

      // reset during EXEC aborts the op and restores priority to requester 0
      req1_valid = 1; req1_op = ALU_AND; req1_a = 32'hFF; req1_b = 32'h3C; rsp1_ready = 1;
      #1;
      check("abort_grant", 32'({req1_ready, req0_ready}), 32'b10);
      tick();
      req1_valid = 0;
      #1;
      check("abort_in_exec", 32'(alu_ctrl), 32'(ALU_AND));
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      check("abort_alu_ctrl", 32'(alu_ctrl), 32'd0);
      check("abort_alu_a", alu_a, 32'd0);
      check("abort_rsp_result", rsp_result, 32'd0);
      for (int k = 0; k < 3; k++) begin
         check("abort_no_rsp", 32'({rsp1_valid, rsp0_valid}), 32'b00);
         tick();
      end
      req0_valid = 1; req1_valid = 1;
      #1;
      check("abort_prio_req0", 32'({req1_ready, req0_ready}), 32'b01);
      req0_valid = 0; req1_valid = 0;
      #1;

      // latency 4 with rsp1 backpressure for three cycles
      d4_req1_valid = 1; d4_req1_op = ALU_AND; d4_req1_a = 32'hFF; d4_req1_b = 32'h3C;
      d4_rsp1_ready = 0;
      #1;
      check("lat4_grant", 32'({d4_req1_ready, d4_req0_ready}), 32'b10);
      tick();
      d4_req1_valid = 0;
      d4_req0_valid = 1; d4_req0_op = ALU_ADD; d4_req0_a = 1; d4_req0_b = 1;
      #1;
      for (int k = 0; k < 4; k++) begin
         check("lat4_alu_ctrl", 32'(d4_alu_ctrl), 32'(ALU_AND));
         check("lat4_alu_a", d4_alu_a, 32'hFF);
         check("lat4_alu_b", d4_alu_b, 32'h3C);
         check("lat4_no_rsp_yet", 32'(d4_rsp1_valid), 32'd0);
         check("lat4_no_grant_exec", 32'(d4_req0_ready), 32'd0);
         tick();
      end
      for (int k = 0; k < 3; k++) begin
         check("lat4_rsp1_held", 32'(d4_rsp1_valid), 32'd1);
         check("lat4_result", d4_rsp_result, 32'h3C);
         check("lat4_no_grant_resp", 32'(d4_req0_ready), 32'd0);
         tick();
      end
      d4_rsp1_ready = 1;
      #1;
      check("lat4_rsp1_last", 32'(d4_rsp1_valid), 32'd1);
      tick();
      check("lat4_grant_after", 32'({d4_req1_ready, d4_req0_ready}), 32'b01);
      d4_req0_valid = 0;
      #1;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
